// File: rtl/tx_5b_scheduler.sv
// tx_5b_scheduler: two-port transmit scheduler for the 4b/5b serial link.
// Arbitrates between two valid/ready byte sources, encodes the winning
// byte into a 12-bit frame (start, two 5-bit codes, stop) and shifts it
// out LSB first on TXD, holding each bit for BIT_CYCLES clocks.
// A frame in flight can be cut short with ABORT.
// Optional build macro: TX_FIXED_PRIORITY_EN -- port 0 always wins
// contention and the round-robin pointer is removed.
module tx_5b_scheduler #(
  parameter int unsigned BIT_CYCLES = 46
) (
  input  logic       CLK_50M,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  input  logic       ABORT,
  output logic       TXD,
  output logic       BUSY,
  output logic [1:0] GRANT,
  output logic [7:0] LAST_BYTE
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Terminal values of the per-bit cycle counter and of the bit index.
  localparam logic [15:0] CNT_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [3:0]  BIT_LAST = 4'd11;

  state_t      state;
  state_t      next_state;

  // Frame bits 11..1 still waiting to go out; bit 0 leaves via txd_q
  // directly at load time, so the shifter only needs eleven stages.
  logic [10:0] pending_sr;
  logic [15:0] cyc_cnt;
  logic [3:0]  bit_idx;
  logic        txd_q;
  logic        busy_q;
  logic [1:0]  grant_q;
  logic [7:0]  last_byte_q;

  logic        prefer1;
  logic        pick1;
  logic        win0;
  logic        win1;
  logic        ready0;
  logic        ready1;
  logic        take0;
  logic        take1;
  logic        load;
  logic        bit_end;
  logic        frame_end;
  logic [7:0]  sel_data;
  logic [11:0] new_frame;

  // 4b/5b nibble code table.
  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0: code = 5'b11110;
      4'h1: code = 5'b01001;
      4'h2: code = 5'b10100;
      4'h3: code = 5'b10101;
      4'h4: code = 5'b01010;
      4'h5: code = 5'b01011;
      4'h6: code = 5'b01110;
      4'h7: code = 5'b01111;
      4'h8: code = 5'b10010;
      4'h9: code = 5'b10011;
      4'hA: code = 5'b10110;
      4'hB: code = 5'b10111;
      4'hC: code = 5'b11010;
      4'hD: code = 5'b11011;
      4'hE: code = 5'b11100;
      4'hF: code = 5'b11101;
    endcase
    return code;
  endfunction

  // Arbitration: a lone requester wins outright; contention goes to the pointer.
  always_comb begin
    pick1 = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) pick1 = prefer1;
  end

  assign win0 = REQ0_VALID & ~pick1;
  assign win1 = REQ1_VALID &  pick1;

  // FSM state register.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode and combinational READY generation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    next_state = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    case (state)
      ST_IDLE: begin
        // ABORT in IDLE only suppresses READY; reset holds READY low too.
        if (!ABORT && !RESET) begin
          ready0 = win0;
          ready1 = win1;
        end
        if ((REQ0_VALID && ready0) || (REQ1_VALID && ready1)) next_state = ST_SEND;
      end
      ST_SEND: begin
        if (ABORT || frame_end) next_state = ST_IDLE;
      end
    endcase
  end

  assign take0     = REQ0_VALID & ready0;
  assign take1     = REQ1_VALID & ready1;
  assign load      = take0 | take1;
  assign bit_end   = (cyc_cnt == CNT_LAST);
  assign frame_end = bit_end && (bit_idx == BIT_LAST);

  // Only one READY can be high, so the data mux needs just one select.
  assign sel_data  = take1 ? REQ1_DATA : REQ0_DATA;
  assign new_frame = {1'b1, enc_4b5b(sel_data[7:4]), enc_4b5b(sel_data[3:0]), 1'b0};

`ifdef TX_FIXED_PRIORITY_EN
  // Fixed priority: port 0 always wins contention; port 1 may starve.
  assign prefer1 = 1'b0;
`else
  // Round-robin pointer: after serving a port, prefer the other on contention.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET)      prefer1 <= 1'b0;
    else if (take0) prefer1 <= 1'b1;
    else if (take1) prefer1 <= 1'b0;
  end
`endif

  // Frame shifter, bit/cycle counters and the registered line driver.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      pending_sr <= '1;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else if (load) begin
      pending_sr <= new_frame[11:1];
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      txd_q      <= new_frame[0];
      busy_q     <= 1'b1;
    end else if (state == ST_SEND) begin
      if (ABORT || frame_end) begin
        // Either the stop bit has run its full time or the frame is
        // discarded; in both cases the line goes back to idle high.
        cyc_cnt <= '0;
        bit_idx <= '0;
        txd_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else if (bit_end) begin
        cyc_cnt    <= '0;
        bit_idx    <= bit_idx + 4'd1;
        txd_q      <= pending_sr[0];
        pending_sr <= {1'b1, pending_sr[10:1]};
      end else begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
    end
  end

  // Grant and last-byte status; kept across ABORT, cleared only by reset.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      grant_q     <= 2'b00;
      last_byte_q <= 8'h00;
    end else if (load) begin
      grant_q     <= take1 ? 2'b10 : 2'b01;
      last_byte_q <= sel_data;
    end
  end

  assign REQ0_READY = ready0;
  assign REQ1_READY = ready1;
  assign TXD        = txd_q;
  assign BUSY       = busy_q;
  assign GRANT      = grant_q;
  assign LAST_BYTE  = last_byte_q;

endmodule

// File: tb/tb_tx_5b_scheduler.sv
// tb_tx_5b_scheduler: directed vectors, multi-cycle corner sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_tx_5b_scheduler;

  localparam int BC        = 4;
  localparam int FRAME_CYC = 12 * BC;

  localparam logic [4:0] CODE [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  logic       CLK_50M    = 1'b0;
  logic       RESET      = 1'b1;
  logic       REQ0_VALID = 1'b0;
  logic [7:0] REQ0_DATA  = 8'h00;
  logic       REQ1_VALID = 1'b0;
  logic [7:0] REQ1_DATA  = 8'h00;
  logic       ABORT      = 1'b0;
  logic       REQ0_READY;
  logic       REQ1_READY;
  logic       TXD;
  logic       BUSY;
  logic [1:0] GRANT;
  logic [7:0] LAST_BYTE;

  int n_cmp = 0;
  int n_bad = 0;

  tx_5b_scheduler #(.BIT_CYCLES(BC)) dut (
    .CLK_50M    (CLK_50M),
    .RESET      (RESET),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_DATA  (REQ0_DATA),
    .REQ0_READY (REQ0_READY),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_DATA  (REQ1_DATA),
    .REQ1_READY (REQ1_READY),
    .ABORT      (ABORT),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .GRANT      (GRANT),
    .LAST_BYTE  (LAST_BYTE)
  );

  always #5 CLK_50M = ~CLK_50M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  // ---------------- reference model (frame level) ----------------
  // Frame bit i is what TXD carries for cycles i*BC .. i*BC+BC-1 of the frame.
  function automatic logic [11:0] build_frame(input logic [7:0] b);
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [11:0] f;
    lo    = CODE[b[3:0]];
    hi    = CODE[b[7:4]];
    f[0]  = 1'b0;
    f[11] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f[1 + i] = lo[i];
      f[6 + i] = hi[i];
    end
    return f;
  endfunction

  bit          m_busy;
  int          m_pos;
  logic [11:0] m_frame;
  bit          m_pref1;
  logic [1:0]  m_grant;
  logic [7:0]  m_last;
  int          mon_win;
  logic        mon_txd;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_pos   = 0;
    m_frame = '1;
    m_pref1 = 1'b0;
    m_grant = 2'b00;
    m_last  = 8'h00;
  endtask

  // Every cycle: compare all outputs mid-cycle, then apply the edge's effect.
  initial begin
    model_reset();
    forever begin
      @(negedge CLK_50M);
      if (RESET) begin
        check("reset_outputs", 32'({TXD, BUSY, REQ0_READY, REQ1_READY, GRANT, LAST_BYTE}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00}));
        model_reset();
      end else begin
        mon_win = -1;
        if (!m_busy && !ABORT) begin
          if (REQ0_VALID && REQ1_VALID) mon_win = m_pref1 ? 1 : 0;
          else if (REQ0_VALID)          mon_win = 0;
          else if (REQ1_VALID)          mon_win = 1;
        end
        mon_txd = m_busy ? m_frame[m_pos / BC] : 1'b1;
        check("cycle_model", 32'({TXD, BUSY, REQ0_READY, REQ1_READY, GRANT, LAST_BYTE}),
              32'({mon_txd, m_busy, mon_win == 0, mon_win == 1, m_grant, m_last}));
        if (m_busy) begin
          if (ABORT) m_busy = 1'b0;
          else begin
            m_pos++;
            if (m_pos == FRAME_CYC) m_busy = 1'b0;
          end
        end else if (mon_win >= 0) begin
          m_last  = (mon_win == 0) ? REQ0_DATA : REQ1_DATA;
          m_frame = build_frame(m_last);
          m_grant = (mon_win == 0) ? 2'b01 : 2'b10;
          m_pos   = 0;
          m_busy  = 1'b1;
`ifndef TX_FIXED_PRIORITY_EN
          m_pref1 = (mon_win == 0);
`endif
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic rdy(input int p);
    return (p == 0) ? REQ0_READY : REQ1_READY;
  endfunction

  task automatic set_valid(input int p, input logic v);
    if (p == 0) REQ0_VALID = v;
    else        REQ1_VALID = v;
  endtask

  // Entered at posedge+1; returns at posedge+1 of the first frame cycle.
  task automatic handshake(input int p, input logic [7:0] data, output bit ok);
    ok = 1'b0;
    if (p == 0) REQ0_DATA = data;
    else        REQ1_DATA = data;
    set_valid(p, 1'b1);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rdy(p) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    set_valid(p, 1'b0);
    check("handshake_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 4 * FRAME_CYC) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(BUSY), 32'd0);
    tick();
  endtask

  typedef struct {
    int          port;
    logic [7:0]  data;
    logic [11:0] frame;   // bit i = TXD during bit i
    logic [1:0]  grant;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vector(input vec_t v);
    bit          ok;
    logic [11:0] got;
    int          n_busy;
    int          n_rdy;
    logic        pre_txd;
    logic        k0_txd;
    got     = '0;
    n_busy  = 0;
    pre_txd = TXD;
    k0_txd  = 1'b1;
    handshake(v.port, v.data, ok);
    n_rdy = int'(ok);
    for (int k = 0; k < FRAME_CYC + 2; k++) begin
      // One stray VALID cycle in the middle of the frame must be ignored.
      if (k == 5 * BC + 1)      set_valid(v.port, 1'b1);
      else if (k == 5 * BC + 2) set_valid(v.port, 1'b0);
      #1;
      if (k == 0) k0_txd = TXD;
      if (rdy(v.port) === 1'b1) n_rdy++;
      if (BUSY === 1'b1) n_busy++;
      if (k < FRAME_CYC && (k % BC) == BC / 2) got[k / BC] = TXD;
      tick();
    end
    check("vec_start_latency", 32'({pre_txd, k0_txd}), 32'(2'b10));
    check("vec_frame_bits",    32'(got),       32'(v.frame));
    check("vec_busy_cycles",   32'(n_busy),    32'(FRAME_CYC));
    check("vec_ready_pulses",  32'(n_rdy),     32'd1);
    check("vec_grant",         32'(GRANT),     32'(v.grant));
    check("vec_last_byte",     32'(LAST_BYTE), 32'(v.data));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit         ok;
    logic [7:0] order [$];
    logic [7:0] exp_order [4];
    logic [7:0] g;
    int         n_busy;
    int         n_low;

    vecs[0] = '{0, 8'hA5, 12'b1101_1001_0110, 2'b01};
    vecs[1] = '{1, 8'h00, 12'b1111_1011_1100, 2'b10};
    vecs[2] = '{0, 8'hFF, 12'b1111_0111_1010, 2'b01};
    vecs[3] = '{1, 8'h3C, 12'b1101_0111_0100, 2'b10};

    // Reset state, with a requester already valid.
    tick();
    REQ0_VALID = 1'b1;
    #1;
    check("rst_txd",   32'(TXD),        32'd1);
    check("rst_busy",  32'(BUSY),       32'd0);
    check("rst_grant", 32'(GRANT),      32'd0);
    check("rst_last",  32'(LAST_BYTE),  32'd0);
    check("rst_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
    REQ0_VALID = 1'b0;
    tick();
    RESET = 1'b0;
    tick();

    // Table-driven single-port frames.
    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Contention straight after reset: alternation (or port-0 only).
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    REQ0_DATA  = 8'h11;
    REQ1_DATA  = 8'h22;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    for (int c = 0; c < 4 * (FRAME_CYC + 2) + 20 && order.size() < 4; c++) begin
      #1;
      if (REQ0_READY === 1'b1) order.push_back(REQ0_DATA);
      if (REQ1_READY === 1'b1) order.push_back(REQ1_DATA);
      tick();
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
`ifdef TX_FIXED_PRIORITY_EN
    exp_order = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    for (int i = 0; i < 4; i++) begin
      g = (i < order.size()) ? order[i] : 8'h00;
      check("rr_order", 32'(g), 32'(exp_order[i]));
    end
    wait_idle();

    // ABORT during bit 5 with port 1 queued.
    handshake(0, 8'hC3, ok);
    REQ1_DATA  = 8'h7E;
    REQ1_VALID = 1'b1;
    repeat (5 * BC + 1) tick();
    ABORT = 1'b1;
    #1;
    check("abort_busy_before", 32'({BUSY, REQ1_READY}), 32'(2'b10));
    tick();
    ABORT = 1'b0;
    #1;
    check("abort_line_idle", 32'({TXD, BUSY}), 32'(2'b10));
    check("abort_kept_status", 32'({GRANT, LAST_BYTE}), 32'({2'b01, 8'hC3}));
    check("abort_queued_ready", 32'(REQ1_READY), 32'd1);
    tick();
    REQ1_VALID = 1'b0;
    check("abort_next_frame", 32'({TXD, BUSY, GRANT, LAST_BYTE}), 32'({1'b0, 1'b1, 2'b10, 8'h7E}));
    wait_idle();

    // ABORT in IDLE only masks READY.
    ABORT      = 1'b1;
    REQ0_DATA  = 8'h99;
    REQ0_VALID = 1'b1;
    #1;
    check("idle_abort_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
    tick();
    check("idle_abort_no_xfer", 32'({BUSY, LAST_BYTE}), 32'({1'b0, 8'h7E}));
    ABORT = 1'b0;
    #1;
    check("idle_abort_release", 32'(REQ0_READY), 32'd1);
    REQ0_VALID = 1'b0;
    tick();

    // RESET pulsed mid-frame: immediate idle line, no stray frame afterwards.
    handshake(0, 8'h5A, ok);
    repeat (3 * BC + 2) tick();
    RESET      = 1'b1;
    REQ0_VALID = 1'b1;
    #1;
    check("midreset_outputs", 32'({TXD, BUSY, REQ0_READY, REQ1_READY, GRANT, LAST_BYTE}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00}));
    tick();
    RESET      = 1'b0;
    REQ0_VALID = 1'b0;
    n_busy = 0;
    n_low  = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      #1;
      if (BUSY !== 1'b0) n_busy++;
      if (TXD !== 1'b1)  n_low++;
      tick();
    end
    check("midreset_no_stray", 32'({n_busy[15:0], n_low[15:0]}), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      REQ0_VALID = ($urandom_range(0, 3) != 0);
      REQ1_VALID = ($urandom_range(0, 3) != 0);
      REQ0_DATA  = 8'($urandom_range(0, 255));
      REQ1_DATA  = 8'($urandom_range(0, 255));
      ABORT      = ($urandom_range(0, 199) == 0);
      tick();
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    ABORT      = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_5b_scheduler.md
# tx_5b_scheduler

Two-port transmit scheduler for the 4b/5b serial link. Accepts bytes from two requesters (port 0: RS-232 receive path, port 1: local status/diagnostic source) over valid/ready handshakes. Arbitrates between them, encodes each byte into a 12-bit 4b/5b frame and serialises it onto the single outgoing TXD line. It replaces the free-running send logic and the global kill latch with a sequenced, abortable controller.

## Interface
- BIT_CYCLES, 46: clock cycles per transmitted bit; legal range 2..65535.
- CLK_50M  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ0_VALID  input  1  port 0 has a byte.
- REQ0_DATA  input  8  port 0 byte.
- REQ0_READY  output  1  port 0 byte accepted this cycle.
- REQ1_VALID / REQ1_DATA / REQ1_READY: same as port 0, for port 1.
- ABORT  input  1  synchronous; terminates the current frame.
- TXD  output  1  serial line, idle high.
- BUSY  output  1  high while a frame is in flight.
- GRANT  output  2  one-hot; the port whose frame is in flight or was sent last.
- LAST_BYTE  output  8  raw byte of the most recently accepted frame (board LEDs).

## Operation
- Reset values: TXD=1, BUSY=0, GRANT=2'b00, LAST_BYTE=8'h00, REQ*_READY=0, state IDLE, round-robin pointer = port 0 preferred.
- States:
  - IDLE: TXD=1. Moves to SEND when a handshake completes.
  - SEND: shifts the frame out. Moves to IDLE after bit 11 completes, or on ABORT.
- Arbitration (IDLE only):
  - Only one valid: that port wins.
  - Both valid: the port not granted last wins.
  - After reset with both valid: port 0 wins.
- REQn_READY is combinational: high when state==IDLE and port n is the winner. At most one READY is high at a time. Outside IDLE, READY is 0.
- A transfer occurs on the rising edge where REQn_VALID && REQn_READY. On that edge:
  - Latch frame: bit0=0 (start); bits[5:1]=code(DATA[3:0]); bits[10:6]=code(DATA[7:4]); bit11=1 (stop).
  - Set GRANT, LAST_BYTE and BUSY=1. Clear the bit counter and the cycle counter. Update the round-robin pointer.
- 4b/5b code, nibble 0..F: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101.
- SEND shifting:
  - TXD = frame bit[bit_idx], transmitted LSB first.
  - The cycle counter runs 0..BIT_CYCLES-1. At terminal count, bit_idx increments.
  - After bit_idx 11 reaches terminal count: state returns to IDLE and BUSY=0.
- ABORT:
  - In SEND: on the next edge, TXD=1, BUSY=0, state IDLE. The partial frame is discarded; GRANT and LAST_BYTE are kept.
  - In IDLE: ABORT has no effect, except that both READYs are forced to 0 while ABORT is high.
- Requesters may drop VALID at any time before the handshake; no byte is taken without a handshake.
- RESET mid-frame: TXD returns to 1 immediately (asynchronous). All state clears.

## Timing
- TXD falls (start bit) on the first edge after the handshake edge: latency 1 cycle.
- Each bit lasts exactly BIT_CYCLES cycles. A frame lasts 12×BIT_CYCLES cycles.
- BUSY is high for exactly 12×BIT_CYCLES cycles, starting the cycle after the handshake.
- After the stop bit there is at least one IDLE cycle (TXD=1) before the next handshake can complete. The next start bit follows 1 cycle after that handshake.
- Back-to-back with both ports valid, grants alternate 0,1,0,1…
- Counters are 16-bit. bit_idx is 4-bit. There is no wrap-around inside a frame.

## Configuration
- TX_FIXED_PRIORITY_EN:
  - Defined: port 0 always wins when both ports are valid. The round-robin pointer is not implemented; port 1 can starve.
  - Undefined: round-robin as described above.

## Test plan
- Port 0 sends 8'hA5 with BIT_CYCLES=4 -> TXD bits 0,1,1,0,1,0,0,1,1,0,1,1, each 4 cycles. LAST_BYTE=A5, GRANT=01, BUSY high for 48 cycles.
- Port 1 sends 8'h00 -> TXD bits 0,0,1,1,1,1,0,1,1,1,1,1. REQ1_READY pulses for one cycle.
- Both ports valid continuously after reset with bytes 11/22 -> frames sent in order 11,22,11,22. With TX_FIXED_PRIORITY_EN defined, only 11 is sent.
- ABORT asserted during bit 5 -> TXD=1 and BUSY=0 on the next edge. A queued port-1 request is handshaken on the following IDLE cycle.
- RESET pulsed mid-frame -> TXD=1 and all outputs at reset values within the same cycle. No stray frame after release.
- REQ0_VALID held for 1 cycle while BUSY -> no READY, no transfer, TXD frame unchanged.
